// File: rtl/imem_loader.sv
// imem_loader: writes a byte-streamed program image into the instruction memory of the
// MIPS core and holds the core's start input (PC clear) until the image is loaded.
//
// Frame: N[15:8], N[7:0], then 4*N data bytes, big-endian words (first byte -> [31:24]).
// Words are written from byte address 0 upward. N must satisfy 1 <= N <= DEPTH.
//
// Optional feature: define IMEM_LOADER_CHKSUM_EN to expect one trailing byte equal to
// the XOR of all data bytes. A mismatch ends in the error state with cpu_start held.
//
// Ports:
//   clk, rst       single clock, synchronous active-high reset
//   load_req       pulse: start a load (ignored while busy)
//   in_valid/in_data/in_ready   byte stream handshake (in_ready depends on state only)
//   imem_we/imem_addr/imem_wdata  instruction memory write port, one strobe per word
//   cpu_start      1 holds the core's PC at 0
//   busy/done/err  load status levels
//   words_loaded   words written in the current/last load
module imem_loader #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_req,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic             cpu_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
`ifdef IMEM_LOADER_CHKSUM_EN
        StChk,
`else
        StFlush,
`endif
        StDone,
        StErr
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       len_q, len_d;      // header count is always two bytes wide
    logic [23:0]       asm_q, asm_d;      // first three bytes of the word being built
    logic [1:0]        bcnt_q, bcnt_d;
    logic [CNT_W-1:0]  words_q, words_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic        accept;
    logic [15:0] n_rx;
    logic        len_ok;
    logic        last_word;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            StLenHi, StLenLo, StData: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
            StChk:                    in_ready = 1'b1;
`endif
            default:                  in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign n_rx      = {len_hi_q, in_data};
    assign len_ok    = (n_rx != 16'd0) && (32'(n_rx) <= DEPTH);
    // Index of the word being completed is words_q: the previous word's increment
    // always lands at least three cycles before the next word's fourth byte.
    assign last_word = (32'(words_q) + 32'd1) == 32'(len_q);

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        asm_d    = asm_q;
        bcnt_d   = bcnt_q;
        words_d  = words_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        start_d  = start_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
`ifdef IMEM_LOADER_CHKSUM_EN
        chk_d    = chk_q;
`endif

        // The count advances on the edge that completes a write.
        if (we_q) begin
            words_d = words_q + 1'b1;
        end

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (load_req) begin
                    state_d = StLenHi;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    words_d = '0;
                    bcnt_d  = 2'd0;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d   = 8'd0;
`endif
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d = n_rx;
                    if (len_ok) begin
                        state_d = StData;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    asm_d  = {asm_q[15:0], in_data};
                    bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHKSUM_EN
                    chk_d  = chk_q ^ in_data;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = 32'({words_q, 2'b00});
                        wdata_d = {asm_q, in_data};
                        if (last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                            state_d = StChk;
`else
                            state_d = StFlush;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHKSUM_EN
            StChk: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (in_data == chk_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        start_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
`else
            // Last word's write is on the bus this cycle; finish as it completes.
            StFlush: begin
                state_d = StDone;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                start_d = 1'b0;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            len_hi_q <= 8'd0;
            len_q    <= 16'd0;
            asm_q    <= 24'd0;
            bcnt_q   <= 2'd0;
            words_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            start_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            asm_q    <= asm_d;
            bcnt_q   <= bcnt_d;
            words_q  <= words_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef IMEM_LOADER_CHKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_start    = start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int DEPTH = 256;
    localparam int CNT_W = 16;
`ifdef IMEM_LOADER_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic             clk;
    logic             rst;
    logic             load_req;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             imem_we;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_wdata;
    logic             cpu_start;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] words_loaded;

    imem_loader #(
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_req    (load_req),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_start   (cpu_start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .words_loaded(words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frame position counting ----------------
    bit          m_ok = 1'b0;
    bit          m_busy = 1'b0;
    int          m_cnt = 0;      // bytes accepted in the current frame
    int          m_n = 0;        // word count from the header
    logic [31:0] m_word = 0;
    logic [7:0]  m_xor = 0;
    bit          m_last = 1'b0;  // the write now on the bus is the frame's final word
    logic        e_we = 1'b0;
    logic [31:0] e_addr = 0;
    logic [31:0] e_wdata = 0;
    logic        e_done = 1'b0;
    logic        e_err = 1'b0;
    logic        e_start = 1'b1;
    int          e_words = 0;
    int          cyc = 0;

    function automatic bit m_ready();
        return m_busy && (m_cnt < 2 || m_cnt < 2 + 4 * m_n + CHK);
    endfunction

    always @(posedge clk) begin : model
        bit acc, busy_pre, we_now, last_now;
        int d;
        cyc++;
        acc      = in_valid && m_ready();
        busy_pre = m_busy;
        we_now   = e_we;
        last_now = m_last;
        if (rst) begin
            m_ok = 1'b1; m_busy = 1'b0; m_cnt = 0; m_n = 0; m_last = 1'b0;
            e_we = 1'b0; e_addr = 0; e_wdata = 0; e_done = 1'b0; e_err = 1'b0;
            e_start = 1'b1; e_words = 0;
        end else begin
            e_we = 1'b0;
            m_last = 1'b0;
            if (we_now) e_words++;
            if (we_now && last_now && CHK == 0) begin
                e_done = 1'b1; m_busy = 1'b0; e_start = 1'b0;
            end
            if (!busy_pre && load_req) begin
                m_busy = 1'b1; m_cnt = 0; m_n = 0; m_xor = 0;
                e_done = 1'b0; e_err = 1'b0; e_words = 0; e_start = 1'b1;
            end else if (acc) begin
                if (m_cnt == 0) begin
                    m_n = int'(in_data) * 256;
                end else if (m_cnt == 1) begin
                    m_n = m_n + int'(in_data);
                    if (m_n < 1 || m_n > DEPTH) begin
                        e_err = 1'b1; m_busy = 1'b0;
                    end
                end else if (m_cnt < 2 + 4 * m_n) begin
                    d = m_cnt - 2;
                    m_word = {m_word[23:0], in_data};
                    m_xor  = m_xor ^ in_data;
                    if (d % 4 == 3) begin
                        e_we = 1'b1;
                        e_addr = 32'((d / 4) * 4);
                        e_wdata = m_word;
                        if (d == 4 * m_n - 1) m_last = 1'b1;
                    end
                end else begin
                    m_busy = 1'b0;
                    if (in_data == m_xor) begin
                        e_done = 1'b1; e_start = 1'b0;
                    end else begin
                        e_err = 1'b1;
                    end
                end
                m_cnt++;
            end
        end
    end

    // ---------------- per-cycle compare + write log ----------------
    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always @(negedge clk) begin
        if (m_ok) begin
            check("in_ready", 32'(in_ready), 32'(m_ready()));
            check("imem_we", 32'(imem_we), 32'(e_we));
            check("imem_addr", imem_addr, e_addr);
            check("imem_wdata", imem_wdata, e_wdata);
            check("cpu_start", 32'(cpu_start), 32'(e_start));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(e_done));
            check("err", 32'(err), 32'(e_err));
            check("words_loaded", 32'(words_loaded), 32'(e_words));
            if (imem_we === 1'b1) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] frame_w[4];
    int          hdr_cyc;

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("send_timeout_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_hdr(input int n, input bit gap);
        logic [15:0] nn;
        nn = 16'(n);
        send_byte(nn[15:8], gap);
        send_byte(nn[7:0], gap);
        hdr_cyc = cyc;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("wait_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    // Full load; chk byte is the computed XOR unless use_lit supplies one.
    task automatic run_frame(input int n, input int nw, input bit gap,
                             input bit use_lit, input logic [7:0] lit_chk);
        logic [7:0] x;
        x = 8'd0;
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        pulse_load();
        send_hdr(n, gap);
        for (int i = 0; i < nw; i++) begin
            send_word(frame_w[i], gap);
            x = x ^ frame_w[i][31:24] ^ frame_w[i][23:16] ^ frame_w[i][15:8] ^ frame_w[i][7:0];
        end
        if (CHK != 0 && nw > 0) send_byte(use_lit ? lit_chk : x, gap);
        in_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        @(negedge clk);
        rst = 1'b0;

        // T1: reset state
        check("t1_cpu_start", 32'(cpu_start), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd0);
        check("t1_done", 32'(done), 32'd0);
        check("t1_err", 32'(err), 32'd0);
        check("t1_busy", 32'(busy), 32'd0);
        check("t1_imem_we", 32'(imem_we), 32'd0);

        // T2: single instruction 20080005
        frame_w[0] = 32'h2008_0005;
        run_frame(1, 1, 1'b0, 1'b0, 8'd0);
        check("t2_nwrites", 32'(wr_cyc.size()), 32'd1);
        if (wr_cyc.size() == 1) begin
            check("t2_addr", wr_addr[0], 32'd0);
            check("t2_data", wr_data[0], 32'h2008_0005);
            check("t2_latency", 32'(wr_cyc[0] - hdr_cyc), 32'd4);
        end
        check("t2_done", 32'(done), 32'd1);
        check("t2_cpu_start", 32'(cpu_start), 32'd0);

        // T3: three words back-to-back; the write for word k sits 4*(k+1) edges after LEN_LO
        frame_w[0] = 32'h1122_3344;
        frame_w[1] = 32'hAABB_CCDD;
        frame_w[2] = 32'h0102_0304;
        run_frame(3, 3, 1'b0, 1'b0, 8'd0);
        check("t3_nwrites", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) begin
            check("t3_cyc0", 32'(wr_cyc[0] - hdr_cyc), 32'd4);
            check("t3_cyc1", 32'(wr_cyc[1] - hdr_cyc), 32'd8);
            check("t3_cyc2", 32'(wr_cyc[2] - hdr_cyc), 32'd12);
            check("t3_addr2", wr_addr[2], 32'd8);
            check("t3_data1", wr_data[1], 32'hAABB_CCDD);
        end
        check("t3_words", 32'(words_loaded), 32'd3);
        check("t3_done", 32'(done), 32'd1);

        // T4: bad lengths, then recovery
        run_frame(0, 0, 1'b0, 1'b0, 8'd0);
        check("t4_n0_err", 32'(err), 32'd1);
        check("t4_n0_ready", 32'(in_ready), 32'd0);
        check("t4_n0_start", 32'(cpu_start), 32'd1);
        check("t4_n0_nwr", 32'(wr_cyc.size()), 32'd0);
        run_frame(DEPTH + 1, 0, 1'b0, 1'b0, 8'd0);
        check("t4_big_err", 32'(err), 32'd1);
        check("t4_big_start", 32'(cpu_start), 32'd1);
        check("t4_big_nwr", 32'(wr_cyc.size()), 32'd0);
        frame_w[0] = 32'hDEAD_BEEF;
        run_frame(1, 1, 1'b0, 1'b0, 8'd0);
        check("t4_rec_done", 32'(done), 32'd1);
        check("t4_rec_err", 32'(err), 32'd0);

        // T5: gapped stream gives the same image as T3
        frame_w[0] = 32'h1122_3344;
        frame_w[1] = 32'hAABB_CCDD;
        frame_w[2] = 32'h0102_0304;
        run_frame(3, 3, 1'b1, 1'b0, 8'd0);
        check("t5_nwrites", 32'(wr_cyc.size()), 32'd3);
        if (wr_cyc.size() == 3) begin
            check("t5_addr1", wr_addr[1], 32'd4);
            check("t5_data0", wr_data[0], 32'h1122_3344);
            check("t5_data2", wr_data[2], 32'h0102_0304);
        end

        // T5b: reset after byte 2 of word 1
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        pulse_load();
        send_hdr(3, 1'b1);
        send_word(32'hCAFE_F00D, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("t5r_nwrites", 32'(wr_cyc.size()), 32'd1);
        check("t5r_busy", 32'(busy), 32'd0);
        check("t5r_ready", 32'(in_ready), 32'd0);
        check("t5r_start", 32'(cpu_start), 32'd1);
        check("t5r_words", 32'(words_loaded), 32'd0);

`ifdef IMEM_LOADER_CHKSUM_EN
        // T6: checksum 8C^09^00^04 = 81
        frame_w[0] = 32'h8C09_0004;
        run_frame(1, 1, 1'b0, 1'b1, 8'h81);
        check("t6_good_done", 32'(done), 32'd1);
        check("t6_good_start", 32'(cpu_start), 32'd0);
        run_frame(1, 1, 1'b0, 1'b1, 8'h80);
        check("t6_bad_err", 32'(err), 32'd1);
        check("t6_bad_start", 32'(cpu_start), 32'd1);
        check("t6_bad_nwr", 32'(wr_cyc.size()), 32'd1);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
